// File: rtl/mod1_decryption.sv
// mod1_decryption: iterative AES-128 inverse cipher, one round per clock, on-the-fly key schedule; optional K10 cache via MOD1_DEC_KEY_CACHE_EN
module mod1_decryption (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [2:0] {IDLE, KEYEXP, FIRST, ROUND, LAST, DONE} state_t;

  state_t        state, state_nx;
  logic [127:0]  st, kr, kr_prev, sb_sr, round_out, kr_init;
  logic [7:0]    rc;
  logic [3:0]    cnt;
  logic          accept, hit;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {r, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_prev(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    return {k[127:96] ^ sub_rot(w3) ^ {r, 24'h0}, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rc_back(input logic [7:0] r);
    return r == 8'h36 ? 8'h1b : r == 8'h1b ? 8'h80 : r >> 1;
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4], mb [4], md [4], me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] x2, x4, x8;
        a[r] = s[127-8*(4*c+r) -: 8];
        x2 = xtime(a[r]);
        x4 = xtime(x2);
        x8 = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                           m9[0] ^ me[1] ^ mb[2] ^ md[3],
                           md[0] ^ m9[1] ^ me[2] ^ mb[3],
                           mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return o;
  endfunction

  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign kr_prev   = key_prev(kr, rc);
  assign sb_sr     = inv_sub_shift(st) ^ kr_prev;
  assign round_out = inv_mix(sb_sr);

`ifdef MOD1_DEC_KEY_CACHE_EN
  logic [127:0] last_key, k10_c;
  logic         cache_vld;
  assign hit     = cache_vld && key == last_key;
  assign kr_init = hit ? k10_c : key;
  // remember the last expanded key; invalidated on a miss until its K10 is ready
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_key  <= '0;
      k10_c     <= '0;
      cache_vld <= 1'b0;
    end else if (accept && !hit) begin
      last_key  <= key;
      cache_vld <= 1'b0;
    end else if (state == KEYEXP && cnt == 4'd9) begin
      k10_c     <= key_expand(kr, rc);
      cache_vld <= 1'b1;
    end
`else
  assign hit     = 1'b0;
  assign kr_init = key;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = hit ? FIRST : KEYEXP;
      KEYEXP:  if (cnt == 4'd9) state_nx = FIRST;
      FIRST:   state_nx = ROUND;
      ROUND:   if (cnt == 4'd1) state_nx = LAST;
      LAST:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath: state, round key, rcon and counter; rc holds on the last expansion step so it sits at 0x36 with K10
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= '0;
      kr       <= '0;
      rc       <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          st  <= data_in;
          kr  <= kr_init;
          rc  <= hit ? 8'h36 : 8'h01;
          cnt <= '0;
        end
        KEYEXP: begin
          kr  <= key_expand(kr, rc);
          rc  <= cnt == 4'd9 ? rc : xtime(rc);
          cnt <= cnt + 4'd1;
        end
        FIRST: begin
          st  <= st ^ kr;
          cnt <= 4'd9;
        end
        ROUND: begin
          kr  <= kr_prev;
          rc  <= rc_back(rc);
          st  <= round_out;
          cnt <= cnt - 4'd1;
        end
        LAST: data_out <= sb_sr;
        default: ;
      endcase
    end
endmodule
